// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, ID/EX control-word layout,
// hazard sequencer state encoding and the bundle of pipeline control strobes.
package mips_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // ID/EX control word: WB[8:7] | M[6:4] | EX[3:0]
  localparam int CTRL_W = 9;
  localparam int WB_HI  = 8;
  localparam int WB_LO  = 7;
  localparam int M_HI   = 6;
  localparam int M_LO   = 4;
  localparam int EX_HI  = 3;
  localparam int EX_LO  = 0;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_src_branch;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
    logic freeze;
  } hz_ctrl_t;

  // Values driven in INIT and while reset is asserted: pipeline emptied, nothing advances.
  localparam hz_ctrl_t CTRL_INIT = '{pc_we: 1'b0, pc_src_branch: 1'b0, ifid_we: 1'b0,
                                     ifid_flush: 1'b1, idex_bubble: 1'b1,
                                     exmem_flush: 1'b1, freeze: 1'b0};

  localparam hz_ctrl_t CTRL_RUN  = '{pc_we: 1'b1, pc_src_branch: 1'b0, ifid_we: 1'b1,
                                     ifid_flush: 1'b0, idex_bubble: 1'b0,
                                     exmem_flush: 1'b0, freeze: 1'b0};

  // R-type, beq and sw read rt as a source; lw and everything else only read rs.
  function automatic logic op_uses_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_R, OP_BEQ, OP_SW: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Register $0 never creates a dependency.
module hazard_cmp
  import mips_pkg::*;
(
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit   = (ex_rt == id_rs);
    rt_hit   = op_uses_rt(id_opcode) && (ex_rt == id_rt);
    load_use = ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch-taken flushes resolved in MEM,
// global freeze while data memory is busy, plus saturating stall/flush counters.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_INIT     | one cycle after reset: flush IF/ID, EX/MEM, bubble ID/EX
//   ST_RUN      | normal issue; branch flush > load-use stall priority
//   ST_MEM_WAIT | data memory busy; whole pipe frozen until dmem_ready
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             pc_src_branch,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  // Arm one count early so the flag is already visible on the MEM_TIMEOUT-th frozen cycle.
  localparam logic [WW-1:0] WAIT_ARM  = WW'(MEM_TIMEOUT - 2);

  hz_state_t state, state_nxt;
  hz_ctrl_t  ctl;
  logic      load_use;
  logic      mem_stall;
  logic      br_flush;
  logic [WW-1:0] wait_cnt;

  hazard_cmp u_cmp (
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctl       = CTRL_INIT;
    mem_stall = 1'b0;
    br_flush  = 1'b0;
    case (state)
      ST_INIT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        ctl = CTRL_RUN;
        if ((state == ST_RUN) ? (mem_access && !dmem_ready) : !dmem_ready) begin
          mem_stall   = 1'b1;
          ctl.freeze  = 1'b1;
          ctl.pc_we   = 1'b0;
          ctl.ifid_we = 1'b0;
          state_nxt   = ST_MEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
          if (mem_branch_taken) begin
            // The load-use consumer sits in IF/ID and is flushed anyway.
            br_flush          = 1'b1;
            ctl.pc_src_branch = 1'b1;
            ctl.ifid_flush    = 1'b1;
            ctl.idex_bubble   = 1'b1;
            ctl.exmem_flush   = 1'b1;
          end else if (load_use) begin
            ctl.pc_we       = 1'b0;
            ctl.ifid_we     = 1'b0;
            ctl.idex_bubble = 1'b1;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_ARM)  mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != ST_INIT) && !ctl.pc_we && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (br_flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign pc_we         = ctl.pc_we;
  assign pc_src_branch = ctl.pc_src_branch;
  assign ifid_we       = ctl.ifid_we;
  assign ifid_flush    = ctl.ifid_flush;
  assign idex_bubble   = ctl.idex_bubble;
  assign exmem_flush   = ctl.exmem_flush;
  assign freeze        = ctl.freeze;

endmodule
